// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer and fetch controller.
// Owns the PC, fetches from a combinational instruction memory, and hands the
// latched instruction to the executor over a valid/ready handshake.
// Optional feature macro: PC_WRAP_TRAP_EN (trap to HALT with err on PC wrap).
//
// Handshake: ir_valid stays high with ir stable from the cycle after FETCH
// until a rising edge where ir_valid & ir_ready; that edge retires ir and
// applies hlt / br_taken / br_target. Those inputs are ignored at other edges.
module pc_seq_ctrl #(
  parameter int AW = 8,
  parameter int IW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  output logic [AW-1:0] pc,
  input  logic [IW-1:0] instr,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          hlt,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [AW-1:0] PC_MAX  = '1;
  localparam logic [CW-1:0] RET_MAX = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          err_q, err_d;
  logic          handshake;

  assign handshake = ir_valid_q & ir_ready;

  // State and datapath registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      retired_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-datapath logic for the fetch/issue loop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    retired_d  = retired_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = start_pc;
          retired_d = '0;
          err_d     = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d       = instr;
        ir_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          ir_valid_d = 1'b0;
          if (retired_q != RET_MAX) retired_d = retired_q + 1'b1;
          if (hlt) begin
            state_d = S_HALT;
          end else if (br_taken) begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end else begin
`ifdef PC_WRAP_TRAP_EN
            if (pc_q == PC_MAX) begin
              // Sequential run off the top of memory: freeze and flag.
              state_d = S_HALT;
              err_d   = 1'b1;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = S_FETCH;
            end
`else
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifndef PC_WRAP_TRAP_EN
    err_d = 1'b0;
`endif
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    busy   = (state_q == S_FETCH) || (state_q == S_ISSUE);
    halted = (state_q == S_HALT);
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign retired  = retired_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed bench for pc_seq_ctrl with a small ROM model.
// Optional feature macro: PC_WRAP_TRAP_EN (selects trap expectations).
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ir_ready, hlt, br_taken;
  logic [7:0]  start_pc, br_target, pc, instr, ir;
  logic        ir_valid, busy, halted, err;
  logic [15:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  // Clock
  always #5 clk = ~clk;

  pc_seq_ctrl #(.AW(8), .IW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc(pc),
    .instr(instr), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .hlt(hlt), .br_taken(br_taken), .br_target(br_target), .busy(busy),
    .halted(halted), .retired(retired), .err(err)
  );

  // Combinational ROM: distinct contents per address
  function automatic logic [7:0] mem(input logic [7:0] a);
    return (a ^ 8'h5A) + 8'h03;
  endfunction
  assign instr = mem(pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ir,
                         input logic e_v, input logic e_busy, input logic e_halt,
                         input logic [15:0] e_ret, input logic e_err);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".ir"}, 32'(ir), 32'(e_ir));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_v));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
    chk({tag, ".retired"}, 32'(retired), 32'(e_ret));
    chk({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = '0; ir_ready = 1'b0;
    hlt = 1'b0; br_taken = 1'b0; br_target = '0;
    step(); step();
    rst = 1'b0;
    chk_all("reset", 8'h00, 8'h00, 0, 0, 0, 16'd0, 0);

    // Start at 0x10, ready held high
    start = 1'b1; start_pc = 8'h10;
    step();
    start = 1'b0; ir_ready = 1'b1;
    chk_all("start_fetch", 8'h10, 8'h00, 0, 1, 0, 16'd0, 0);
    step();
    chk_all("issue10", 8'h10, mem(8'h10), 1, 1, 0, 16'd0, 0);
    step();
    chk_all("fetch11", 8'h11, mem(8'h10), 0, 1, 0, 16'd1, 0);

    // Stall 5 cycles in ISSUE at 0x11
    ir_ready = 1'b0;
    step();
    chk_all("issue11", 8'h11, mem(8'h11), 1, 1, 0, 16'd1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("stall", 8'h11, mem(8'h11), 1, 1, 0, 16'd1, 0);
    end
    ir_ready = 1'b1;
    step();
    chk_all("after_stall", 8'h12, mem(8'h11), 0, 1, 0, 16'd2, 0);

    // Branch at 0x12 to 0x40
    step();
    chk_all("issue12", 8'h12, mem(8'h12), 1, 1, 0, 16'd2, 0);
    br_taken = 1'b1; br_target = 8'h40;
    step();
    br_taken = 1'b0; br_target = 8'h00;
    chk_all("branch", 8'h40, mem(8'h12), 0, 1, 0, 16'd3, 0);
    step();
    chk_all("issue40", 8'h40, mem(8'h40), 1, 1, 0, 16'd3, 0);
    step();
    chk_all("fetch41", 8'h41, mem(8'h40), 0, 1, 0, 16'd4, 0);

    // Branch again to 0x12, then hlt+br_taken together: hlt wins
    step();
    br_taken = 1'b1; br_target = 8'h12;
    step();
    br_taken = 1'b0;
    step();
    chk_all("issue12b", 8'h12, mem(8'h12), 1, 1, 0, 16'd5, 0);
    hlt = 1'b1; br_taken = 1'b1; br_target = 8'h77;
    step();
    hlt = 1'b0; br_taken = 1'b0;
    chk_all("hlt_over_br", 8'h12, mem(8'h12), 0, 0, 1, 16'd6, 0);
    step(); step();
    chk_all("halt_frozen", 8'h12, mem(8'h12), 0, 0, 1, 16'd6, 0);

    // Restart from 0x00
    start = 1'b1; start_pc = 8'h00;
    step();
    start = 1'b0;
    chk_all("restart", 8'h00, mem(8'h12), 0, 1, 0, 16'd0, 0);
    step();
    chk_all("issue00", 8'h00, mem(8'h00), 1, 1, 0, 16'd0, 0);
    // start is ignored while busy
    start = 1'b1; start_pc = 8'h99;
    step();
    start = 1'b0;
    chk_all("start_ignored", 8'h01, mem(8'h00), 0, 1, 0, 16'd1, 0);
    step();
    hlt = 1'b1;
    step();
    hlt = 1'b0;
    chk_all("halt01", 8'h01, mem(8'h01), 0, 0, 1, 16'd2, 0);

    // Wrap at 0xFF
    start = 1'b1; start_pc = 8'hFF;
    step();
    start = 1'b0;
    step();
    chk_all("issueFF", 8'hFF, mem(8'hFF), 1, 1, 0, 16'd0, 0);
    step();
`ifdef PC_WRAP_TRAP_EN
    chk_all("wrap_trap", 8'hFF, mem(8'hFF), 0, 0, 1, 16'd1, 1);
    // start clears err
    start = 1'b1; start_pc = 8'h05;
    step();
    start = 1'b0;
    chk_all("err_clear", 8'h05, mem(8'hFF), 0, 1, 0, 16'd0, 0);
`else
    chk_all("wrap", 8'h00, mem(8'hFF), 0, 1, 0, 16'd1, 0);
    step();
    chk_all("issue_wrap0", 8'h00, mem(8'h00), 1, 1, 0, 16'd1, 0);
`endif

    // Reset pulse, then mid-handshake reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("reset2", 8'h00, 8'h00, 0, 0, 0, 16'd0, 0);
    start = 1'b1; start_pc = 8'h20;
    step();
    start = 1'b0;
    step();
    step();
    chk_all("fetch21", 8'h21, mem(8'h20), 0, 1, 0, 16'd1, 0);
    step();
    chk_all("issue21", 8'h21, mem(8'h21), 1, 1, 0, 16'd1, 0);
    rst = 1'b1; br_taken = 1'b1; br_target = 8'h33;
    step();
    rst = 1'b0; br_taken = 1'b0;
    chk_all("mid_rst", 8'h00, 8'h00, 0, 0, 0, 16'd0, 0);
    step();
    chk_all("idle_hold", 8'h00, 8'h00, 0, 0, 0, 16'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
